particle_plotter: RTL and testbench
===================================

# particle_plotter

Rasterises particle screen coordinates into the framebuffer. Sits directly downstream of the position-transform pipeline: it accepts its per-particle integer (x, y) screen coordinates under a valid-only strobe and buffers them in a small FIFO. It stamps a STAMP×STAMP square of PARTICLE_COLOR per particle into framebuffer memory through a one-write-per-cycle port. On request it first clears the whole frame to BG_COLOR.

## Interface
Parameters:
- SCREEN_W, 320, framebuffer width in pixels
- SCREEN_H, 180, framebuffer height in pixels
- STAMP, 2, side of square drawn per particle (1..4)
- FIFO_DEPTH, 8, coordinate buffer entries (power of 2)
- COLOR_W, 4, pixel width
- PARTICLE_COLOR, 4'hF, particle pixel value
- BG_COLOR, 4'h0, clear value

Ports (one clock; reset is asynchronous and active-low):
- clk_in  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- coord_in  input  [1:0][31:0]  signed screen coords; [0]=x, [1]=y
- data_valid_in  input  1  coord_in valid this cycle; no backpressure
- frame_start  input  1  single-cycle request to clear the framebuffer
- fb_addr  output  16  write address = y*SCREEN_W + x
- fb_data  output  COLOR_W  write data
- fb_we  output  1  write enable
- clear_done  output  1  one-cycle pulse with the final clear write
- busy  output  1  state != IDLE or FIFO non-empty
- dropped_count  output  16  saturating count of coords lost to a full FIFO

## Operation
- FSM states: IDLE, CLEAR, DRAW.
- Push:
  - data_valid_in with FIFO not full → push.
  - Full is taken from the registered count, so a push while full is dropped even if a pop occurs the same cycle.
  - A dropped push increments dropped_count, which saturates at 16'hFFFF and is cleared only by reset.
  - Pushes are accepted in every state, including CLEAR.
- frame_start:
  - Sets a pending flag in IDLE or DRAW; it is ignored while in CLEAR.
  - The pending flag is serviced in IDLE, or at the end of the current particle's stamp in DRAW. It takes priority over popping.
- CLEAR:
  - Writes BG_COLOR to addresses 0..SCREEN_W*SCREEN_H-1, one per cycle, ascending.
  - Then goes to DRAW if the FIFO is non-empty, else IDLE.
- DRAW:
  - A popped coordinate (x, y) produces STAMP² pixel slots (x+dx, y+dy), with dx the fastest-varying index, both 0..STAMP-1.
  - A slot with signed x+dx outside [0, SCREEN_W) or y+dy outside [0, SCREEN_H) is clipped: fb_we=0 but the cycle is still consumed.
  - On the last slot: pop the next coordinate if the FIFO is non-empty and nothing is pending, else service pending, else go to IDLE.
- Address arithmetic: 32-bit signed compare; the product y*SCREEN_W uses the in-range y only, and the result is truncated to 16 bits.
- Outputs during IDLE: fb_we=0; fb_addr and fb_data hold their last value.

## Timing
- Reset values: fb_addr=0, fb_data=0, fb_we=0, clear_done=0, busy=0, dropped_count=0. FIFO empty, state IDLE, pending cleared.
- All outputs are registered.
- Push latency: a coord pushed at cycle t can be popped at t+1 at the earliest.
- Draw latency: pop at cycle t → slot k presented on the fb_* outputs at t+1+k. Back-to-back particles have no bubble.
- Clear latency: frame_start serviced at cycle t → addr 0 at t+1, addr N-1 at t+N (N=57600 at defaults), with clear_done high at t+N.
- Reset mid-CLEAR or mid-DRAW: the operation is abandoned, the FIFO is emptied, and there are no further writes until new input.

## Structure
- Package plot_pkg holds:
  - SCREEN_W/SCREEN_H defaults
  - FB_ADDR_W=16
  - the plot_state_t enum {IDLE, CLEAR, DRAW}
  - the screen_coord_t packed [1:0][31:0] type, shared with the transform stage
- Sub-module coord_fifo: synchronous FIFO with count, full, empty, and the same async active-low reset. The FSM, stamp counters, clip and address logic live in particle_plotter.

## Test plan
- Single push (10,20), STAMP=2 → writes at addresses 6410, 6411, 6730, 6731 on four consecutive cycles, starting 2 cycles after the push; busy falls the cycle after the last write.
- Push (319,179) → only address 57599 is written; the 3 clipped slots have fb_we=0 and still take one cycle each. Push (-1,-1) → only address 0 is written.
- frame_start from IDLE → 57600 ascending BG_COLOR writes, clear_done coincident with addr 57599. A second frame_start mid-clear is ignored.
- 12 pushes on consecutive cycles during CLEAR, FIFO_DEPTH=8 → dropped_count=4; after clear, the 8 buffered particles draw back-to-back, 32 slots with no gap.
- frame_start during DRAW of (5,5) → all 4 slots complete, then CLEAR starts the next cycle, ahead of queued coordinates.
- Assert rst_n low mid-clear → all outputs 0 and FIFO empty immediately; after release there are no writes until the next push.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types and defaults for the particle plotter
// and the upstream position-transform stage.
package plot_pkg;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 180;
  localparam int FB_ADDR_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DRAW
  } plot_state_t;

  typedef logic [1:0][31:0] screen_coord_t;

endpackage

// File: rtl/coord_fifo.sv
// Show-ahead synchronous FIFO buffering particle
// screen coordinates ahead of the rasteriser.
module coord_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  screen_coord_t din,
  output screen_coord_t dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  screen_coord_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/particle_plotter.sv
// Stamps buffered particle coordinates into the framebuffer
// and clears the frame to background on request.
module particle_plotter
  import plot_pkg::*;
#(
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int STAMP      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int COLOR_W    = 4,
  parameter logic [COLOR_W-1:0] PARTICLE_COLOR = 4'hF,
  parameter logic [COLOR_W-1:0] BG_COLOR       = 4'h0
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  screen_coord_t        coord_in,
  input  logic                 data_valid_in,
  input  logic                 frame_start,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  output logic                 fb_we,
  output logic                 clear_done,
  output logic                 busy,
  output logic [15:0]          dropped_count
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [FB_ADDR_W-1:0] LAST =
    FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [1:0] SMAX = 2'(STAMP - 1);

  screen_coord_t  head;
  logic [CW:0]    fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  plot_state_t          state;
  logic                 pending;
  logic                 pend;
  logic signed [31:0]   cur_x;
  logic signed [31:0]   cur_y;
  logic [1:0]           dx;
  logic [1:0]           dy;
  logic [FB_ADDR_W-1:0] clr_cnt;

  logic signed [31:0]   xs;
  logic signed [31:0]   ys;
  logic                 in_x;
  logic                 in_y;
  logic                 last_slot;
  logic [FB_ADDR_W-1:0] pix_addr;

  coord_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .push   (data_valid_in),
    .pop    (pop),
    .din    (coord_in),
    .dout   (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // frame_start counts as pending in its own cycle
  assign pend      = pending || frame_start;
  assign last_slot = (dx == SMAX) && (dy == SMAX);
  assign xs        = cur_x + $signed({30'd0, dx});
  assign ys        = cur_y + $signed({30'd0, dy});
  assign in_x      = (xs >= 0) && (xs < SCREEN_W);
  assign in_y      = (ys >= 0) && (ys < SCREEN_H);
  assign pix_addr  = FB_ADDR_W'(
    (in_y ? ys : 32'sd0) * SCREEN_W + (in_x ? xs : 32'sd0));

  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = !pend && !fifo_empty;
      CLEAR:   pop = (clr_cnt == LAST) && !fifo_empty;
      DRAW:    pop = last_slot && !pend && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      cur_x         <= '0;
      cur_y         <= '0;
      dx            <= '0;
      dy            <= '0;
      clr_cnt       <= '0;
      fb_addr       <= '0;
      fb_data       <= '0;
      fb_we         <= 1'b0;
      clear_done    <= 1'b0;
      busy          <= 1'b0;
      dropped_count <= '0;
    end else begin
      clear_done <= 1'b0;
      busy       <= (state != IDLE) || (fifo_count != '0);
      if (data_valid_in && fifo_full && dropped_count != 16'hFFFF)
        dropped_count <= dropped_count + 16'd1;
      if (frame_start && state != CLEAR)
        pending <= 1'b1;
      unique case (state)
        IDLE: begin
          fb_we <= 1'b0;
          if (pend) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            pending <= 1'b0;
          end else if (!fifo_empty) begin
            state <= DRAW;
          end
        end
        CLEAR: begin
          fb_we   <= 1'b1;
          fb_addr <= clr_cnt;
          fb_data <= BG_COLOR;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            clear_done <= 1'b1;
            state      <= fifo_empty ? IDLE : DRAW;
          end
        end
        DRAW: begin
          fb_we <= in_x && in_y;
          if (in_x && in_y) begin
            fb_addr <= pix_addr;
            fb_data <= PARTICLE_COLOR;
          end
          if (dx == SMAX) begin
            dx <= '0;
            dy <= dy + 2'd1;
          end else begin
            dx <= dx + 2'd1;
          end
          if (last_slot) begin
            if (pend) begin
              state   <= CLEAR;
              clr_cnt <= '0;
              pending <= 1'b0;
            end else if (fifo_empty) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        cur_x <= $signed(head[0]);
        cur_y <= $signed(head[1]);
        dx    <= '0;
        dy    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_particle_plotter.sv
// Scoreboard bench for particle_plotter: stamping, clipping,
// clear, overflow, preemption and reset behaviour.
module tb_particle_plotter;
  import plot_pkg::*;

  localparam int W = 320;
  localparam int H = 180;
  localparam int N = W * H;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  data;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  screen_coord_t coord_in = '0;
  logic          data_valid_in = 1'b0;
  logic          frame_start = 1'b0;
  logic [15:0]   fb_addr;
  logic [3:0]    fb_data;
  logic          fb_we;
  logic          clear_done;
  logic          busy;
  logic [15:0]   dropped_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk_in = ~clk_in;

  particle_plotter #(
    .SCREEN_W       (W),
    .SCREEN_H       (H),
    .STAMP          (2),
    .FIFO_DEPTH     (8),
    .COLOR_W        (4),
    .PARTICLE_COLOR (4'hF),
    .BG_COLOR       (4'h0)
  ) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .coord_in      (coord_in),
    .data_valid_in (data_valid_in),
    .frame_start   (frame_start),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we),
    .clear_done    (clear_done),
    .busy          (busy),
    .dropped_count (dropped_count)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic exp_t px(int x, int y);
    exp_t e;
    e.we   = 1'b1;
    e.addr = 16'(y * W + x);
    e.data = 4'hF;
    return e;
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    return e;
  endfunction

  task automatic push_xy(int x, int y);
    coord_in[0]   = 32'(x);
    coord_in[1]   = 32'(y);
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    n_cmp += 6;
    if (fb_we !== 1'b0) begin
      n_bad++; $display("FAIL reset_we: got %b want 0", fb_we);
    end
    if (fb_addr !== 16'd0) begin
      n_bad++; $display("FAIL reset_addr: got %0d want 0", fb_addr);
    end
    if (fb_data !== 4'd0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", fb_data);
    end
    if (clear_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_done: got %b want 0", clear_done);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    if (dropped_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_drop: got %0d want 0", dropped_count);
    end
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    push_xy(10, 20);
    sb.push_back(idle_e());
    sb.push_back(idle_e());
    sb.push_back(px(10, 20));
    sb.push_back(px(11, 20));
    sb.push_back(px(10, 21));
    sb.push_back(px(11, 21));
    sb.push_back(idle_e());
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      @(negedge clk_in);
      n_cmp++;
      if (fb_we !== e.we ||
          (e.we && (fb_addr !== e.addr || fb_data !== e.data))) begin
        n_bad++;
        $display("FAIL single_slot%0d: we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                 i, fb_we, fb_addr, fb_data, e.we, e.addr, e.data);
      end
      if (i == 5 || i == 6) begin
        n_cmp++;
        if (busy !== (i == 5)) begin
          n_bad++;
          $display("FAIL single_busy%0d: got %b want %b", i, busy, i == 5);
        end
      end
      tick();
    end
  endtask

  task automatic test_clip();
    exp_t e;
    push_xy(319, 179);
    sb.push_back(idle_e());
    sb.push_back(idle_e());
    sb.push_back(px(319, 179));
    repeat (4) sb.push_back(idle_e());
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      @(negedge clk_in);
      n_cmp++;
      if (fb_we !== e.we || (e.we && fb_addr !== e.addr)) begin
        n_bad++;
        $display("FAIL clip_hi%0d: we=%b addr=%0d want we=%b addr=%0d",
                 i, fb_we, fb_addr, e.we, e.addr);
      end
      if (i == 5 || i == 6) begin
        n_cmp++;
        if (busy !== (i == 5)) begin
          n_bad++;
          $display("FAIL clip_busy%0d: got %b want %b", i, busy, i == 5);
        end
      end
      tick();
    end
    push_xy(-1, -1);
    repeat (5) sb.push_back(idle_e());
    sb.push_back(px(0, 0));
    sb.push_back(idle_e());
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      @(negedge clk_in);
      n_cmp++;
      if (fb_we !== e.we || (e.we && fb_addr !== e.addr)) begin
        n_bad++;
        $display("FAIL clip_lo%0d: we=%b addr=%0d want we=%b addr=%0d",
                 i, fb_we, fb_addr, e.we, e.addr);
      end
      tick();
    end
  endtask

  task automatic test_clear_overflow();
    exp_t e;
    int   bad = 0;
    int   first_bad = -1;
    int   model_cnt = 0;
    int   found = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      @(posedge clk_in);
      #1;
      if (k <= 12) begin
        coord_in[0]   = 32'(10 * (k - 1) + 3);
        coord_in[1]   = 32'(2 * (k - 1) + 1);
        data_valid_in = 1'b1;
        if (model_cnt < 8) begin
          sb.push_back(px(10 * (k - 1) + 3, 2 * (k - 1) + 1));
          sb.push_back(px(10 * (k - 1) + 4, 2 * (k - 1) + 1));
          sb.push_back(px(10 * (k - 1) + 3, 2 * (k - 1) + 2));
          sb.push_back(px(10 * (k - 1) + 4, 2 * (k - 1) + 2));
          model_cnt++;
        end
      end else begin
        data_valid_in = 1'b0;
      end
      frame_start = (k == 200);
      @(negedge clk_in);
      if (fb_we !== 1'b1 || fb_addr !== 16'(k - 1) ||
          fb_data !== 4'h0 || clear_done !== (k == N)) begin
        if (first_bad < 0) first_bad = k;
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL clear_seq: %0d bad cycles, first at %0d, want 0 bad",
               bad, first_bad);
    end
    n_cmp++;
    if (dropped_count !== 16'd4) begin
      n_bad++;
      $display("FAIL drop_count: got %0d want 4", dropped_count);
    end
    for (int w = 0; w < 4; w++) begin
      tick();
      @(negedge clk_in);
      if (fb_we === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_cmp++;
    if (found == 0) begin
      n_bad++;
      $display("FAIL draw_start: no write within 4 cycles of clear, want 1");
      sb.delete();
    end
    for (int j = 0; sb.size() > 0; j++) begin
      e = sb.pop_front();
      n_cmp++;
      if (fb_we !== 1'b1 || fb_addr !== e.addr || fb_data !== e.data) begin
        n_bad++;
        $display("FAIL burst_slot%0d: we=%b addr=%0d data=%h want addr=%0d data=%h",
                 j, fb_we, fb_addr, fb_data, e.addr, e.data);
      end
      tick();
      @(negedge clk_in);
    end
    n_cmp++;
    if (fb_we !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_end: we=%b addr=%0d want we=0", fb_we, fb_addr);
    end
    tick();
  endtask

  task automatic test_preempt();
    exp_t e;
    push_xy(5, 5);
    push_xy(50, 50);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    sb.push_back(px(5, 5));
    sb.push_back(px(6, 5));
    sb.push_back(px(5, 6));
    sb.push_back(px(6, 6));
    for (int k = 0; k < 10; k++) begin
      e.we   = 1'b1;
      e.addr = 16'(k);
      e.data = 4'h0;
      sb.push_back(e);
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      @(negedge clk_in);
      n_cmp++;
      if (fb_we !== e.we || fb_addr !== e.addr || fb_data !== e.data) begin
        n_bad++;
        $display("FAIL preempt_slot%0d: we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                 i, fb_we, fb_addr, fb_data, e.we, e.addr, e.data);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (fb_we !== 1'b0 || fb_addr !== 16'd0 || fb_data !== 4'd0) begin
      n_bad++;
      $display("FAIL midrst_fb: we=%b addr=%0d data=%h want all 0",
               fb_we, fb_addr, fb_data);
    end
    if (clear_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_flags: done=%b busy=%b want 0 0",
               clear_done, busy);
    end
    if (dropped_count !== 16'd0) begin
      n_bad++;
      $display("FAIL midrst_drop: got %0d want 0", dropped_count);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if (fb_we !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL post_rst%0d: we=%b busy=%b want 0 0", i, fb_we, busy);
      end
    end
    tick();
  endtask

  task automatic test_after_reset();
    exp_t e;
    push_xy(1, 1);
    sb.push_back(idle_e());
    sb.push_back(idle_e());
    sb.push_back(px(1, 1));
    sb.push_back(px(2, 1));
    sb.push_back(px(1, 2));
    sb.push_back(px(2, 2));
    sb.push_back(idle_e());
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      @(negedge clk_in);
      n_cmp++;
      if (fb_we !== e.we ||
          (e.we && (fb_addr !== e.addr || fb_data !== e.data))) begin
        n_bad++;
        $display("FAIL restart_slot%0d: we=%b addr=%0d want we=%b addr=%0d",
                 i, fb_we, fb_addr, e.we, e.addr);
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_clip();
    test_clear_overflow();
    test_preempt();
    test_reset_mid();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
